// File: rtl/spgd_dither_ctrl.sv
// SPGD dither sequencer: +/- dithered DAC steps, two metric captures, then a signed base update.
// Optional measurement watchdog is compiled in when SPGD_TIMEOUT_EN is defined.
module spgd_dither_ctrl #(
  parameter int          FLOAT_WIDTH   = 64,
  parameter int          DAC_WIDTH     = 14,
  parameter int          SETTLE_WIDTH  = 16,
  parameter int          INIT_CODE     = 8192,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          TIMEOUT_WIDTH = 20
) (
  input  logic                    ADC_CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [SETTLE_WIDTH-1:0] SETTLE_CYCLES,
  input  logic [DAC_WIDTH-1:0]    DITHER_AMP,
  input  logic [5:0]              GAIN_SHIFT,
  input  logic [FLOAT_WIDTH-1:0]  METRIC,
  input  logic                    MEAS_DONE,
  output logic                    MEAS_EN,
  output logic [DAC_WIDTH-1:0]    DAC_CODE_OUT,
  output logic                    DITHER_SIGN,
  output logic [31:0]             ITER_COUNT,
  output logic                    BUSY,
  output logic                    TIMEOUT
);

  localparam int FRAC_BITS = FLOAT_WIDTH - 16;
  localparam int UW        = ((DAC_WIDTH > 17) ? DAC_WIDTH : 17) + 2;
  localparam logic signed [UW-1:0] CODE_MAX = UW'((1 << DAC_WIDTH) - 1);
  localparam logic [DAC_WIDTH-1:0] INIT_DAC  = DAC_WIDTH'(INIT_CODE);
  localparam logic [15:0]          LFSR_TAPS = 16'hB400;

  typedef enum logic [3:0] {
    IDLE,
    SET_P,
    SETTLE_P,
    MEAS_P,
    CAP_P,
    SET_N,
    SETTLE_N,
    MEAS_N,
    CAP_N,
    UPDATE
  } state_t;

  state_t                  state_q, state_d;
  logic [DAC_WIDTH-1:0]    base_q, base_d;
  logic [DAC_WIDTH-1:0]    dac_q, dac_d;
  logic [15:0]             lfsr_q, lfsr_d, lfsr_step;
  logic [31:0]             iter_q, iter_d;
  logic [SETTLE_WIDTH-1:0] cnt_q, cnt_d, settle_last;
  logic [FLOAT_WIDTH-1:0]  jp_q, jp_d, jn_q, jn_d;
  logic                    meas_en_q, meas_en_d;
  logic                    cap_first_q, cap_first_d;
  logic                    abort;
  logic                    wd_expired;

  logic signed [FLOAT_WIDTH:0] diff, diff_sh;
  logic signed [16:0]          q_int;
  logic signed [UW-1:0]        base_ext, amp_ext, step, base_sum;
  logic signed [UW-1:0]        code_plus_raw, code_minus_raw;
  logic [DAC_WIDTH-1:0]        code_plus, code_minus, base_new;

  function automatic logic [DAC_WIDTH-1:0] sat_code(input logic signed [UW-1:0] v);
    if (v[UW-1])
      sat_code = '0;
    else if (v > CODE_MAX)
      sat_code = '1;
    else
      sat_code = DAC_WIDTH'(v);
  endfunction

  // Dither codes: "plus" phase is base + s*AMP, "minus" phase is base - s*AMP.
  assign base_ext       = $signed({{(UW-DAC_WIDTH){1'b0}}, base_q});
  assign amp_ext        = $signed({{(UW-DAC_WIDTH){1'b0}}, DITHER_AMP});
  assign code_plus_raw  = lfsr_q[0] ? (base_ext + amp_ext) : (base_ext - amp_ext);
  assign code_minus_raw = lfsr_q[0] ? (base_ext - amp_ext) : (base_ext + amp_ext);
  assign code_plus      = sat_code(code_plus_raw);
  assign code_minus     = sat_code(code_minus_raw);

  // One extra bit keeps Jp - Jn exact; the arithmetic shift floors toward -inf.
  assign diff     = $signed({jp_q[FLOAT_WIDTH-1], jp_q}) - $signed({jn_q[FLOAT_WIDTH-1], jn_q});
  assign diff_sh  = diff >>> GAIN_SHIFT;
  assign q_int    = 17'(diff_sh >>> FRAC_BITS);
  assign step     = lfsr_q[0] ? $signed({{(UW-17){q_int[16]}}, q_int})
                              : -$signed({{(UW-17){q_int[16]}}, q_int});
  assign base_sum = base_ext + step;
  assign base_new = sat_code(base_sum);

  assign lfsr_step   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign settle_last = (SETTLE_CYCLES == '0) ? '0 : (SETTLE_CYCLES - SETTLE_WIDTH'(1));

`ifdef SPGD_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     timeout_q;

  always_comb begin
    wd_d = '0;
    if (state_q == MEAS_P || state_q == CAP_P || state_q == MEAS_N || state_q == CAP_N)
      wd_d = wd_q + TIMEOUT_WIDTH'(1);
  end

  assign wd_expired = &wd_d;

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_q | wd_expired;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign wd_expired = 1'b0;
  assign TIMEOUT    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    dac_d       = dac_q;
    lfsr_d      = lfsr_q;
    iter_d      = iter_q;
    cnt_d       = cnt_q;
    jp_d        = jp_q;
    jn_d        = jn_q;
    meas_en_d   = 1'b0;
    cap_first_d = 1'b0;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        dac_d = base_q;
        if (START)
          state_d = SET_P;
      end
      SET_P: begin
        dac_d   = code_plus;
        cnt_d   = '0;
        state_d = SETTLE_P;
      end
      SETTLE_P: begin
        if (cnt_q >= settle_last) begin
          cnt_d     = '0;
          meas_en_d = 1'b1;
          state_d   = MEAS_P;
        end else begin
          cnt_d = cnt_q + SETTLE_WIDTH'(1);
        end
      end
      MEAS_P: begin
        if (MEAS_DONE) begin
          cap_first_d = 1'b1;
          state_d     = CAP_P;
        end else begin
          meas_en_d = 1'b1;
        end
      end
      CAP_P: begin
        // Sample exactly once, on the cycle after MEAS_DONE was accepted.
        if (cap_first_q)
          jp_d = METRIC;
        if (!MEAS_DONE)
          state_d = SET_N;
      end
      SET_N: begin
        dac_d   = code_minus;
        cnt_d   = '0;
        state_d = SETTLE_N;
      end
      SETTLE_N: begin
        if (cnt_q >= settle_last) begin
          cnt_d     = '0;
          meas_en_d = 1'b1;
          state_d   = MEAS_N;
        end else begin
          cnt_d = cnt_q + SETTLE_WIDTH'(1);
        end
      end
      MEAS_N: begin
        if (MEAS_DONE) begin
          cap_first_d = 1'b1;
          state_d     = CAP_N;
        end else begin
          meas_en_d = 1'b1;
        end
      end
      CAP_N: begin
        if (cap_first_q)
          jn_d = METRIC;
        if (!MEAS_DONE)
          state_d = UPDATE;
      end
      UPDATE: begin
        base_d  = base_new;
        dac_d   = base_new;
        iter_d  = iter_q + 32'd1;
        lfsr_d  = lfsr_step;
        state_d = START ? SET_P : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // UPDATE always completes; everywhere else a dropped START or watchdog abandons the iteration.
    if ((state_q != IDLE && state_q != UPDATE && !START) || wd_expired)
      abort = 1'b1;

    if (abort) begin
      state_d     = IDLE;
      dac_d       = base_q;
      meas_en_d   = 1'b0;
      cap_first_d = 1'b0;
    end
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      base_q      <= INIT_DAC;
      dac_q       <= INIT_DAC;
      lfsr_q      <= LFSR_SEED;
      iter_q      <= '0;
      cnt_q       <= '0;
      jp_q        <= '0;
      jn_q        <= '0;
      meas_en_q   <= 1'b0;
      cap_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      dac_q       <= dac_d;
      lfsr_q      <= lfsr_d;
      iter_q      <= iter_d;
      cnt_q       <= cnt_d;
      jp_q        <= jp_d;
      jn_q        <= jn_d;
      meas_en_q   <= meas_en_d;
      cap_first_q <= cap_first_d;
    end
  end

  assign MEAS_EN      = meas_en_q;
  assign DAC_CODE_OUT = dac_q;
  assign DITHER_SIGN  = lfsr_q[0];
  assign ITER_COUNT   = iter_q;
  assign BUSY         = (state_q != IDLE);

endmodule

// File: tb/tb_spgd_dither_ctrl.sv
// Directed bench for spgd_dither_ctrl: hand-computed DAC codes, base updates and LFSR signs per iteration.
`timescale 1ns/1ps
module tb_spgd_dither_ctrl;

  localparam logic [63:0] J_0     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] J_1     = 64'h0001_0000_0000_0000;  // 1.0
  localparam logic [63:0] J_2     = 64'h0002_0000_0000_0000;  // 2.0
  localparam logic [63:0] J_HALF  = 64'h0000_8000_0000_0000;  // 0.5
  localparam logic [63:0] J_8187  = 64'h1FFB_0000_0000_0000;
  localparam logic [63:0] J_64    = 64'h0040_0000_0000_0000;
  localparam logic [63:0] J_20000 = 64'h4E20_0000_0000_0000;
  localparam logic [63:0] J_5000  = 64'h1388_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] settle;
  logic [13:0] amp;
  logic [5:0]  shift;
  logic [63:0] metric;
  logic        meas_done;
  logic        meas_en;
  logic [13:0] dac;
  logic        sign;
  logic [31:0] iter;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spgd_dither_ctrl #(.TIMEOUT_WIDTH(8)) dut (
    .ADC_CLK      (clk),
    .RST          (rst),
    .START        (start),
    .SETTLE_CYCLES(settle),
    .DITHER_AMP   (amp),
    .GAIN_SHIFT   (shift),
    .METRIC       (metric),
    .MEAS_DONE    (meas_done),
    .MEAS_EN      (meas_en),
    .DAC_CODE_OUT (dac),
    .DITHER_SIGN  (sign),
    .ITER_COUNT   (iter),
    .BUSY         (busy),
    .TIMEOUT      (timeout)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Waits for MEAS_EN, checks latency and DAC code, then answers with one metric value.
  task automatic meas_phase(input string tag, input int exp_lat, input int exp_dac,
                            input logic [63:0] jval);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_en && n < 500);
    check_val({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check_val({tag, "_dac"}, 64'(dac), 64'(exp_dac));
    check_val({tag, "_busy"}, 64'(busy), 64'd1);
    metric    = jval;
    meas_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (meas_en && n < 500);
    check_val({tag, "_en_drop"}, 64'(n), 64'd1);
    meas_done = 1'b0;
  endtask

  task automatic run_iter(input int idx, input logic [5:0] sh, input int lat_p,
                          input int exp_p, input int exp_n,
                          input logic [63:0] jp, input logic [63:0] jn,
                          input int exp_base, input logic exp_sign);
    int n;
    string t;
    t     = $sformatf("it%0d", idx);
    shift = sh;
    meas_phase({t, "p"}, lat_p, exp_p, jp);
    meas_phase({t, "n"}, 6, exp_n, jn);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (iter == 32'(idx - 1) && n < 50);
    check_val({t, "_upd_lat"}, 64'(n), 64'd2);
    check_val({t, "_base"}, 64'(dac), 64'(exp_base));
    check_val({t, "_sign"}, 64'(sign), 64'(exp_sign));
    check_val({t, "_iter"}, 64'(iter), 64'(idx));
    $display("iter %0d: dac+ %0d dac- %0d -> base %0d sign %0d count %0d",
             idx, exp_p, exp_n, dac, sign, iter);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    settle    = 16'd4;
    amp       = 14'd100;
    shift     = 6'd0;
    metric    = '0;
    meas_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_val("rst_dac", 64'(dac), 64'd8192);
    check_val("rst_meas_en", 64'(meas_en), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_iter", 64'(iter), 64'd0);
    check_val("rst_timeout", 64'(timeout), 64'd0);
    check_val("rst_sign", 64'(sign), 64'd1);
    $display("reset: dac %0d busy %0d iter %0d", dac, busy, iter);

    start = 1'b1;
    //        idx sh lat  dac+   dac-   Jp      Jn       base   sign
    run_iter(1, 0, 6,  8292,  8092,  J_2,    J_1,     8193,  1'b0);
    run_iter(2, 0, 5,  8093,  8293,  J_2,    J_1,     8192,  1'b0);
    run_iter(3, 0, 5,  8092,  8292,  J_0,    J_HALF,  8193,  1'b0);
    run_iter(4, 0, 5,  8093,  8293,  J_0,    J_8187,  16380, 1'b0);
    run_iter(5, 2, 5,  16280, 16383, J_0,    J_64,    16383, 1'b1);
    run_iter(6, 0, 5,  16383, 16283, J_0,    J_20000, 0,     1'b1);
    run_iter(7, 0, 5,  100,   0,     J_5000, J_0,     5000,  1'b1);

    // Drop START while settling the minus phase.
    meas_phase("it8p", 5, 5100, J_2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dac != 14'd4900 && n < 50);
    check_val("abort_setn_lat", 64'(n), 64'd2);
    check_val("abort_setn_dac", 64'(dac), 64'd4900);
    start = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_dac", 64'(dac), 64'd5000);
    check_val("abort_meas_en", 64'(meas_en), 64'd0);
    check_val("abort_iter", 64'(iter), 64'd7);
    $display("abort: dac %0d busy %0d iter %0d", dac, busy, iter);

    // Asynchronous reset while a measurement is pending.
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_en && n < 50);
    check_val("mid_meas_lat", 64'(n), 64'd6);
    check_val("mid_meas_dac", 64'(dac), 64'd5100);
    #2 rst = 1'b1;
    #1;
    check_val("arst_dac", 64'(dac), 64'd8192);
    check_val("arst_meas_en", 64'(meas_en), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_iter", 64'(iter), 64'd0);
    check_val("arst_sign", 64'(sign), 64'd1);
    $display("async reset: dac %0d meas_en %0d iter %0d", dac, meas_en, iter);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef SPGD_TIMEOUT_EN
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_en && n < 50);
    check_val("wd_meas_lat", 64'(n), 64'd6);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout && n < 1000);
    check_val("wd_cycles", 64'(n), 64'd255);
    check_val("wd_busy", 64'(busy), 64'd0);
    check_val("wd_meas_en", 64'(meas_en), 64'd0);
    check_val("wd_dac", 64'(dac), 64'd8192);
    check_val("wd_iter", 64'(iter), 64'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("wd_sticky", 64'(timeout), 64'd1);
    $display("watchdog: cycles %0d timeout %0d dac %0d", n, timeout, dac);
`else
    repeat (3) @(negedge clk);
    check_val("no_wd_timeout", 64'(timeout), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
